// File: rtl/sim_pcie_user_pkg.sv
// Shared encodings and widths for the simulated PCIe user endpoint.
package sim_pcie_user_pkg;

    localparam int         CNT_W    = 16;
    localparam int         IDX_W    = 16;
    localparam logic [3:0] KEEP_ALL = 4'hF;

    typedef enum logic [1:0] {
        C_IDLE,
        C_REQ,
        C_NEXT,
        C_DONE
    } cfg_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_SEND,
        T_GAP
    } tx_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sim_pcie_rx_checker.sv
// Checks the bridge RX stream for the incrementing-word pattern and tlast framing.
module sim_pcie_rx_checker
    import sim_pcie_user_pkg::*;
#(
    parameter int RX_PKT_WORDS = 128
) (
    input  logic             sys_clk_p,
    input  logic             sys_reset,
    input  logic             lnk_up,
    input  logic             rx_enable,
    input  logic [31:0]      rx_tdata,
    input  logic [3:0]       rx_tkeep,
    input  logic             rx_tlast,
    input  logic             rx_tvalid,
    output logic             rx_tready,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err
);

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(RX_PKT_WORDS - 1);

    logic [IDX_W-1:0] k;
    logic             beat;
    logic             beat_err;

    // One error per beat, however many of the individual checks fail on it.
    always_comb begin
        beat     = rx_tvalid & rx_tready & lnk_up;
        beat_err = (rx_tdata != 32'(k))
                 | (rx_tkeep != KEEP_ALL)
                 | (rx_tlast && (k < LAST_K))
                 | (!rx_tlast && (k == LAST_K));
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge sys_clk_p or posedge sys_reset) begin
        if (sys_reset) begin
            rx_tready <= 1'b0;
            k         <= '0;
            pkt_count <= '0;
            err_count <= '0;
            err       <= 1'b0;
        end else begin
            rx_tready <= rx_enable;
            if (!lnk_up) begin
                k <= '0;
            end else if (beat) begin
                k <= rx_tlast ? '0 : k + IDX_W'(1);
                if (rx_tlast) pkt_count <= pkt_count + CNT_W'(1);
                if (beat_err) begin
                    err_count <= sat_inc(err_count);
                    err       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sim_pcie_user_endpoint.sv
// User-side endpoint for the simulated PCIe bridge: CFG BAR reader, RX checker, TX packet source.
module sim_pcie_user_endpoint
    import sim_pcie_user_pkg::*;
#(
    parameter int          RX_PKT_WORDS  = 128,
    parameter int          TX_PKT_WORDS  = 128,
    parameter logic [31:0] TX_SEED       = 32'h0,
    parameter int          TX_GAP_CYCLES = 4,
    parameter int          CFG_FIRST_DW  = 4,
    parameter int          CFG_NUM_DW    = 6
) (
    input  logic             sys_clk_p,
    input  logic             sys_reset,
    input  logic             i_user_lnk_up,
    input  logic             i_user_enable_comm,
    input  logic             i_tx_enable,
    input  logic [31:0]      i_rx_tdata,
    input  logic [3:0]       i_rx_tkeep,
    input  logic             i_rx_tlast,
    input  logic             i_rx_tvalid,
    output logic             o_rx_tready,
    output logic [31:0]      o_tx_tdata,
    output logic [3:0]       o_tx_tkeep,
    output logic [3:0]       o_tx_tuser,
    output logic             o_tx_tlast,
    output logic             o_tx_tvalid,
    input  logic             i_tx_tready,
    output logic [9:0]       o_cfg_dwaddr,
    output logic             o_cfg_rd_en,
    input  logic [31:0]      i_cfg_do,
    input  logic             i_cfg_rd_wr_done,
    output logic             o_cfg_done,
    output logic [31:0]      o_bar0,
    output logic [31:0]      o_bar1,
    output logic [CNT_W-1:0] o_rx_pkt_count,
    output logic [CNT_W-1:0] o_rx_err_count,
    output logic             o_rx_err,
    output logic [CNT_W-1:0] o_tx_pkt_count
);

    localparam int               CFG_IDX_W = $clog2(CFG_NUM_DW + 1);
    localparam int               GAP_W     = (TX_GAP_CYCLES > 1) ? $clog2(TX_GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((TX_GAP_CYCLES > 0) ? TX_GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] TX_LAST   = IDX_W'(TX_PKT_WORDS - 1);

    cfg_state_t           cfg_state, cfg_next;
    logic [CFG_IDX_W-1:0] cfg_idx;
    logic                 cfg_capture;

    tx_state_t            tx_state, tx_next;
    logic [IDX_W-1:0]     tx_beat;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 comm_en;
    logic                 tx_accept;
    logic                 tx_last;

    // ---------------- CFG BAR reader ----------------
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cfg_next = cfg_state;
        if (!i_user_lnk_up) begin
            cfg_next = C_IDLE;
        end else begin
            case (cfg_state)
                C_IDLE:  cfg_next = C_REQ;
                C_REQ:   if (i_cfg_rd_wr_done) cfg_next = C_NEXT;
                C_NEXT:  cfg_next = (cfg_idx == CFG_IDX_W'(CFG_NUM_DW)) ? C_DONE : C_REQ;
                C_DONE:  cfg_next = C_DONE;
                default: cfg_next = C_IDLE;
            endcase
        end
    end

    always_comb begin
        o_cfg_rd_en  = (cfg_state == C_REQ);
        o_cfg_dwaddr = o_cfg_rd_en ? 10'(CFG_FIRST_DW) + 10'(cfg_idx) : '0;
        o_cfg_done   = (cfg_state == C_DONE);
        cfg_capture  = o_cfg_rd_en & i_cfg_rd_wr_done & i_user_lnk_up;
    end

    // Captured BARs survive a link drop; a re-read simply overwrites them.
    always_ff @(posedge sys_clk_p or posedge sys_reset) begin
        if (sys_reset) begin
            cfg_state <= C_IDLE;
            cfg_idx   <= '0;
            o_bar0    <= '0;
            o_bar1    <= '0;
        end else begin
            cfg_state <= cfg_next;
            if (!i_user_lnk_up) begin
                cfg_idx <= '0;
            end else if (cfg_capture) begin
                cfg_idx <= cfg_idx + CFG_IDX_W'(1);
                if (cfg_idx == CFG_IDX_W'(0)) o_bar0 <= i_cfg_do;
                if (cfg_idx == CFG_IDX_W'(1)) o_bar1 <= i_cfg_do;
            end
        end
    end

    // ---------------- RX checker ----------------
    sim_pcie_rx_checker #(
        .RX_PKT_WORDS(RX_PKT_WORDS)
    ) u_rx_checker (
        .sys_clk_p (sys_clk_p),
        .sys_reset (sys_reset),
        .lnk_up    (i_user_lnk_up),
        .rx_enable (o_cfg_done & i_user_lnk_up),
        .rx_tdata  (i_rx_tdata),
        .rx_tkeep  (i_rx_tkeep),
        .rx_tlast  (i_rx_tlast),
        .rx_tvalid (i_rx_tvalid),
        .rx_tready (o_rx_tready),
        .pkt_count (o_rx_pkt_count),
        .err_count (o_rx_err_count),
        .err       (o_rx_err)
    );

    // ---------------- TX packet source ----------------
    always_comb begin
        tx_accept = (tx_state == T_SEND) & i_tx_tready;
        tx_last   = (tx_beat == TX_LAST);
        tx_next   = tx_state;
        if (!i_user_lnk_up) begin
            tx_next = T_IDLE;
        end else begin
            case (tx_state)
                T_IDLE:  if (o_cfg_done && comm_en && i_tx_enable) tx_next = T_SEND;
                T_SEND:  if (tx_accept && tx_last) tx_next = (TX_GAP_CYCLES == 0) ? T_IDLE : T_GAP;
                T_GAP:   if (gap_cnt == GAP_LAST) tx_next = T_IDLE;
                default: tx_next = T_IDLE;
            endcase
        end
    end

    // Beat data is derived from the beat index, so it holds by itself across a stall.
    always_comb begin
        o_tx_tvalid = (tx_state == T_SEND);
        o_tx_tdata  = o_tx_tvalid ? TX_SEED + 32'(tx_beat) : '0;
        o_tx_tlast  = o_tx_tvalid & tx_last;
        o_tx_tkeep  = KEEP_ALL;
        o_tx_tuser  = 4'h0;
    end

    always_ff @(posedge sys_clk_p or posedge sys_reset) begin
        if (sys_reset) begin
            tx_state       <= T_IDLE;
            tx_beat        <= '0;
            gap_cnt        <= '0;
            comm_en        <= 1'b0;
            o_tx_pkt_count <= '0;
        end else begin
            tx_state <= tx_next;
            gap_cnt  <= (tx_state == T_GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (!i_user_lnk_up) begin
                tx_beat <= '0;
                comm_en <= 1'b0;
            end else begin
                if (i_user_enable_comm) comm_en <= 1'b1;
                if (tx_accept) begin
                    tx_beat <= tx_last ? '0 : tx_beat + IDX_W'(1);
                    if (tx_last) o_tx_pkt_count <= o_tx_pkt_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
